// File: rtl/inputc_nvc.sv
// Router input channel: per-VC flit FIFOs, per-VC packet FSMs requesting and
// holding an output port, and a round-robin registered output stream with credits.
module inputc_nvc #(
  parameter int NVC   = 4,
  parameter int DEPTH = 4,
  parameter int DATAW = 32,
  parameter int PORTW = 3,
  parameter int VCW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic [DATAW-1:0]     idata,
  input  logic                 ivalid,
  input  logic [VCW-1:0]       ivch,
  output logic [NVC-1:0]       ocredit,
  output logic [NVC-1:0]       req,
  output logic [NVC*PORTW-1:0] req_port,
  input  logic [NVC-1:0]       grt,
  input  logic [NVC-1:0]       irdy,
  output logic [DATAW-1:0]     odata,
  output logic                 ovalid,
  output logic [VCW-1:0]       ovch,
  output logic [NVC-1:0]       olck,
  output logic                 ovf
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  typedef enum logic [1:0] {FT_BODY, FT_HEAD, FT_TAIL, FT_HEADTAIL} flit_type_e;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACTIVE} vc_state_e;

  function automatic logic is_head(input flit_type_e t);
    return (t == FT_HEAD) || (t == FT_HEADTAIL);
  endfunction

  function automatic logic is_tail(input flit_type_e t);
    return (t == FT_TAIL) || (t == FT_HEADTAIL);
  endfunction

  function automatic logic [VCW-1:0] next_vc(input logic [VCW-1:0] v, input int step);
    return VCW'((int'(v) + step) % NVC);
  endfunction

  logic [DATAW-1:0] mem    [NVC][DEPTH];
  logic [PTRW-1:0]  wr_ptr [NVC];
  logic [PTRW-1:0]  rd_ptr [NVC];
  logic [CNTW-1:0]  count  [NVC];
  vc_state_e        state  [NVC];
  logic [VCW-1:0]   rr_ptr;

  logic [DATAW-1:0] front [NVC];
  flit_type_e       front_type [NVC];
  logic [NVC-1:0]   not_empty, full, elig, push, drop, pop;
  logic             sel_valid;
  logic [VCW-1:0]   sel_vc, cand;

  always_comb begin
    for (int v = 0; v < NVC; v++) begin
      front[v]      = mem[v][rd_ptr[v]];
      front_type[v] = flit_type_e'(front[v][DATAW-1 -: 2]);
      not_empty[v]  = (count[v] != '0);
      full[v]       = (count[v] == CNTW'(DEPTH));
      elig[v]       = (state[v] == S_ACTIVE) && not_empty[v] && irdy[v];
      // Full is judged on the pre-dequeue occupancy, so a full FIFO rejects
      // a write even in the cycle it is being drained.
      push[v]       = ivalid && (ivch == VCW'(v)) && !full[v];
      drop[v]       = ivalid && (ivch == VCW'(v)) && full[v];
    end
  end

  // Round-robin: first eligible VC at or after the pointer.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the loop can leave a latch behind.
    sel_valid = 1'b0;
    sel_vc    = '0;
    cand      = '0;
    for (int i = 0; i < NVC; i++) begin
      cand = next_vc(rr_ptr, i);
      if (!sel_valid && elig[cand]) begin
        sel_valid = 1'b1;
        sel_vc    = cand;
      end
    end
    for (int v = 0; v < NVC; v++) pop[v] = sel_valid && (sel_vc == VCW'(v));
  end

  // NOTE: flit storage has no reset; the pointers and counts alone define
  // which entries are live, so flushing them empties every FIFO.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NVC; v++) begin
      if (push[v]) mem[v][wr_ptr[v]] <= idata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      for (int v = 0; v < NVC; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        count[v]  <= '0;
        state[v]  <= S_IDLE;
      end
      rr_ptr   <= '0;
      req      <= '0;
      req_port <= '0;
      olck     <= '0;
      odata    <= '0;
      ovalid   <= 1'b0;
      ovch     <= '0;
      ocredit  <= '0;
      ovf      <= 1'b0;
    end else begin
      if (|drop) ovf <= 1'b1;

      for (int v = 0; v < NVC; v++) begin
        if (push[v]) wr_ptr[v] <= wr_ptr[v] + PTRW'(1);
        if (pop[v])  rd_ptr[v] <= rd_ptr[v] + PTRW'(1);
        count[v] <= count[v] + CNTW'(push[v]) - CNTW'(pop[v]);

        unique case (state[v])
          S_IDLE: begin
            // A non-head front flit is a protocol error: hold and wait.
            if (not_empty[v] && is_head(front_type[v])) begin
              state[v]                   <= S_REQ;
              req[v]                     <= 1'b1;
              req_port[v*PORTW +: PORTW] <= front[v][DATAW-3 -: PORTW];
            end
          end
          S_REQ: begin
            if (grt[v]) begin
              state[v] <= S_ACTIVE;
              req[v]   <= 1'b0;
              olck[v]  <= 1'b1;
            end
          end
          S_ACTIVE: begin
            if (pop[v] && is_tail(front_type[v])) begin
              state[v] <= S_IDLE;
              olck[v]  <= 1'b0;
            end
          end
          default: state[v] <= S_IDLE;
        endcase
      end

      ovalid  <= sel_valid;
      ovch    <= sel_valid ? sel_vc : '0;
      odata   <= sel_valid ? front[sel_vc] : '0;
      ocredit <= pop;
      if (sel_valid) rr_ptr <= next_vc(sel_vc, 1);
    end
  end

endmodule

// File: tb/tb_inputc_nvc.sv
// Directed bench for inputc_nvc: a queue-based reference model checked every
// cycle, plus literal expectations on flit order, credits, req and ovf.
module tb_inputc_nvc;

  localparam logic [1:0] BODY = 2'b00, HEAD = 2'b01, TAIL = 2'b10, HT = 2'b11;

  logic        clk = 1'b0;
  logic        rst_ = 1'b1;
  logic [31:0] idata = '0;
  logic        ivalid = 1'b0;
  logic [1:0]  ivch = '0;
  logic [3:0]  ocredit, req, olck;
  logic [11:0] req_port;
  logic [3:0]  grt = '0;
  logic [3:0]  irdy = 4'b1111;
  logic [31:0] odata;
  logic        ovalid;
  logic [1:0]  ovch;
  logic        ovf;

  inputc_nvc #(.NVC(4), .DEPTH(4), .DATAW(32), .PORTW(3), .VCW(2)) dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .ocredit(ocredit), .req(req), .req_port(req_port), .grt(grt), .irdy(irdy),
    .odata(odata), .ovalid(ovalid), .ovch(ovch), .olck(olck), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mq [4][$];
  int          mph [4];           // 0 idle, 1 requesting, 2 holding port
  logic [2:0]  mport [4];
  int          mrr, m_served;
  logic        m_full, model_live = 1'b0;
  logic [31:0] mf;
  logic        e_ovalid, e_ovf;
  logic [31:0] e_odata;
  logic [1:0]  e_ovch;
  logic [3:0]  e_ocredit, e_req, e_olck;
  logic [11:0] e_port;

  always @(posedge clk) begin
    if (rst_) begin
      for (int v = 0; v < 4; v++) begin
        mq[v].delete();
        mph[v] = 0;
        mport[v] = '0;
      end
      mrr = 0;
      e_ovalid = 0; e_odata = '0; e_ovch = '0; e_ocredit = '0; e_ovf = 0;
      model_live = 1'b1;
    end else begin
      m_served = -1;
      for (int i = 0; i < 4; i++) begin
        if (m_served < 0 && mph[(mrr+i)%4] == 2 && mq[(mrr+i)%4].size() > 0 && irdy[(mrr+i)%4])
          m_served = (mrr + i) % 4;
      end
      m_full = ivalid && (mq[ivch].size() == 4);
      for (int v = 0; v < 4; v++) begin
        if (mq[v].size() > 0) mf = mq[v][0]; else mf = '0;
        if (mph[v] == 0 && mq[v].size() > 0 && mf[30]) begin
          mph[v] = 1;
          mport[v] = mf[29:27];
        end else if (mph[v] == 1 && grt[v]) begin
          mph[v] = 2;
        end else if (mph[v] == 2 && m_served == v && mf[31]) begin
          mph[v] = 0;
        end
      end
      if (m_served >= 0) begin
        e_ovalid  = 1;
        e_odata   = mq[m_served].pop_front();
        e_ovch    = 2'(m_served);
        e_ocredit = 4'(1 << m_served);
        mrr       = (m_served + 1) % 4;
      end else begin
        e_ovalid = 0; e_odata = '0; e_ovch = '0; e_ocredit = '0;
      end
      if (ivalid) begin
        if (m_full) e_ovf = 1;
        else mq[ivch].push_back(idata);
      end
    end
    for (int v = 0; v < 4; v++) begin
      e_req[v]  = (mph[v] == 1);
      e_olck[v] = (mph[v] == 2);
    end
    e_port = {mport[3], mport[2], mport[1], mport[0]};
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("ovalid",   ovalid,   e_ovalid);
      check("odata",    odata,    e_odata);
      check("ovch",     ovch,     e_ovch);
      check("ocredit",  ocredit,  e_ocredit);
      check("req",      req,      e_req);
      check("req_port", req_port, e_port);
      check("olck",     olck,     e_olck);
      check("ovf",      ovf,      e_ovf);
    end
  end

  // ---------------- observation of the output stream ----------------
  logic [33:0] obs [$];
  logic [33:0] exp_q [$];
  int          cred_cnt [4];

  always @(negedge clk) begin
    if (model_live && !rst_) begin
      if (ovalid) obs.push_back({ovch, odata});
      for (int v = 0; v < 4; v++) if (ocredit[v]) cred_cnt[v]++;
    end
  end

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [2:0] p, input logic [26:0] pay);
    return {t, p, pay};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int vc, input logic [31:0] d);
    ivalid = 1'b1; ivch = 2'(vc); idata = d;
    @(negedge clk);
    ivalid = 1'b0; idata = '0;
  endtask

  task automatic expf(input int vc, input logic [31:0] d);
    exp_q.push_back({2'(vc), d});
  endtask

  task automatic check_list(input string name);
    check({name, "_count"}, obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) check(name, obs[i], exp_q[i]);
    exp_q.delete();
    obs.delete();
  endtask

  task automatic wait_req(input int v);
    int k = 0;
    while (!req[v] && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("wait_req", req[v], 1'b1);
  endtask

  task automatic pulse_grt(input logic [3:0] g);
    grt = g;
    @(negedge clk);
    grt = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    rst_ = 1'b0;
    obs.delete();
    for (int v = 0; v < 4; v++) cred_cnt[v] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int v = 0; v < 4; v++) cred_cnt[v] = 0;
    step(2);
    do_reset();
    check("rst_ovalid", ovalid, 1'b0);
    check("rst_req", req, 4'h0);
    check("rst_ovf", ovf, 1'b0);

    // 1: single packet on VC1, port 2
    send(1, mk(HEAD, 3'd2, 27'h11));
    check("t1_req_early", req[1], 1'b0);
    send(1, mk(BODY, 3'd0, 27'h12));
    check("t1_req", req[1], 1'b1);
    check("t1_port", req_port[5:3], 3'd2);
    send(1, mk(TAIL, 3'd0, 27'h13));
    pulse_grt(4'b0010);
    check("t1_olck", olck[1], 1'b1);
    step(1);
    check("t1_head_out", odata, mk(HEAD, 3'd2, 27'h11));
    check("t1_head_cred", ocredit, 4'b0010);
    step(6);
    check("t1_olck_off", olck[1], 1'b0);
    check("t1_credits", cred_cnt[1], 3);
    expf(1, mk(HEAD, 3'd2, 27'h11));
    expf(1, mk(BODY, 3'd0, 27'h12));
    expf(1, mk(TAIL, 3'd0, 27'h13));
    check_list("t1_flits");

    // 2: interleaved packets on VC0 and VC2
    do_reset();
    send(0, mk(HEAD, 3'd1, 27'h21));
    send(2, mk(HEAD, 3'd3, 27'h31));
    send(0, mk(BODY, 3'd0, 27'h22));
    send(2, mk(BODY, 3'd0, 27'h32));
    send(0, mk(TAIL, 3'd0, 27'h23));
    send(2, mk(BODY, 3'd0, 27'h33));
    send(2, mk(TAIL, 3'd0, 27'h34));
    wait_req(0);
    wait_req(2);
    check("t2_ports", {req_port[8:6], req_port[2:0]}, {3'd3, 3'd1});
    pulse_grt(4'b0101);
    step(10);
    expf(0, mk(HEAD, 3'd1, 27'h21));
    expf(2, mk(HEAD, 3'd3, 27'h31));
    expf(0, mk(BODY, 3'd0, 27'h22));
    expf(2, mk(BODY, 3'd0, 27'h32));
    expf(0, mk(TAIL, 3'd0, 27'h23));
    expf(2, mk(BODY, 3'd0, 27'h33));
    expf(2, mk(TAIL, 3'd0, 27'h34));
    check_list("t2_flits");

    // 3: overflow on VC3 while stalled
    do_reset();
    irdy = 4'b0111;
    send(3, mk(HEAD, 3'd4, 27'h41));
    send(3, mk(BODY, 3'd0, 27'h42));
    send(3, mk(BODY, 3'd0, 27'h43));
    send(3, mk(TAIL, 3'd0, 27'h44));
    check("t3_ovf_before", ovf, 1'b0);
    send(3, mk(HT, 3'd7, 27'h45));
    check("t3_ovf", ovf, 1'b1);
    wait_req(3);
    pulse_grt(4'b1000);
    step(5);
    check("t3_stalled", obs.size(), 0);
    irdy = 4'b1111;
    step(8);
    check("t3_ovf_sticky", ovf, 1'b1);
    check("t3_credits", cred_cnt[3], 4);
    expf(3, mk(HEAD, 3'd4, 27'h41));
    expf(3, mk(BODY, 3'd0, 27'h42));
    expf(3, mk(BODY, 3'd0, 27'h43));
    expf(3, mk(TAIL, 3'd0, 27'h44));
    check_list("t3_flits");

    // 4: HEADTAIL waiting on a late grant
    do_reset();
    check("t4_ovf_cleared", ovf, 1'b0);
    send(0, mk(HT, 3'd5, 27'h51));
    step(1);
    for (int i = 0; i < 5; i++) begin
      check("t4_req_hold", req[0], 1'b1);
      check("t4_no_out", ovalid, 1'b0);
      step(1);
    end
    pulse_grt(4'b0001);
    step(1);
    check("t4_out", ovalid, 1'b1);
    check("t4_idle_olck", olck[0], 1'b0);
    check("t4_idle_req", req[0], 1'b0);
    step(2);
    expf(0, mk(HT, 3'd5, 27'h51));
    check_list("t4_flits");

    // 5: irdy[1] toggling every cycle during a 4-flit packet
    do_reset();
    send(1, mk(HEAD, 3'd1, 27'h61));
    send(1, mk(BODY, 3'd0, 27'h62));
    send(1, mk(BODY, 3'd0, 27'h63));
    send(1, mk(TAIL, 3'd0, 27'h64));
    wait_req(1);
    pulse_grt(4'b0010);
    for (int i = 0; i < 12; i++) begin
      irdy[1] = ~irdy[1];
      step(1);
    end
    irdy = 4'b1111;
    step(4);
    check("t5_credits", cred_cnt[1], 4);
    expf(1, mk(HEAD, 3'd1, 27'h61));
    expf(1, mk(BODY, 3'd0, 27'h62));
    expf(1, mk(BODY, 3'd0, 27'h63));
    expf(1, mk(TAIL, 3'd0, 27'h64));
    check_list("t5_flits");

    // 6: reset mid-packet flushes without credits, then a fresh packet
    do_reset();
    irdy = 4'b1011;
    send(2, mk(HEAD, 3'd3, 27'h71));
    send(2, mk(BODY, 3'd0, 27'h72));
    send(2, mk(BODY, 3'd0, 27'h73));
    wait_req(2);
    pulse_grt(4'b0100);
    step(3);
    check("t6_olck", olck[2], 1'b1);
    rst_ = 1'b1;
    step(1);
    rst_ = 1'b0;
    check("t6_rst_olck", olck, 4'h0);
    check("t6_rst_req", req, 4'h0);
    check("t6_rst_port", req_port, 12'h0);
    check("t6_rst_out", {ovalid, ovch, odata}, 35'h0);
    check("t6_rst_cred", ocredit, 4'h0);
    irdy = 4'b1111;
    step(4);
    check("t6_no_cred", cred_cnt[2], 0);
    check("t6_no_out", obs.size(), 0);
    send(2, mk(HEAD, 3'd6, 27'h81));
    send(2, mk(TAIL, 3'd0, 27'h82));
    wait_req(2);
    check("t6_port", req_port[8:6], 3'd6);
    pulse_grt(4'b0100);
    step(6);
    check("t6_credits", cred_cnt[2], 2);
    expf(2, mk(HEAD, 3'd6, 27'h81));
    expf(2, mk(TAIL, 3'd0, 27'h82));
    check_list("t6_flits");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
